stream_packer: RTL and testbench
================================

// Module: stream_packer
// PURPOSE
//  Downstream stage of the buffered FIFO: packs RATIO consecutive DATA_WIDTH words
//  into one RATIO*DATA_WIDTH word for wide consumers (bus writer, BSRAM bank).
//  Valid/ready on both sides; a double-buffered design (accumulator + output register)
//  sustains 1 input word/cycle. Partial words are emitted on flush_i, with a per-lane keep mask.
// PARAMETERS
//  DATA_WIDTH  11  input word width
//  RATIO       4   input words per output word (>=2); lane 0 = first word, at LSBs
//  TIMEOUT     64  idle cycles before auto-flush (used only with STREAM_PACKER_TIMEOUT_EN)
// PORTS
//  clk_i    in   1                 clock, all state on rising edge
//  rst_i    in   1                 reset, asynchronous, active-high
//  data_i   in   DATA_WIDTH        input word
//  valid_i  in   1                 input word valid
//  ready_o  out  1                 input accepted when valid_i && ready_o
//  flush_i  in   1                 single-cycle request: emit current partial word
//  data_o   out  RATIO*DATA_WIDTH  packed word; unused lanes driven 0
//  keep_o   out  RATIO             lane-valid mask, contiguous from bit 0
//  valid_o  out  1                 packed word valid, held until accepted
//  ready_i  in   1                 downstream accept
// BEHAVIOUR
//  Reset: valid_o=0, data_o=0, keep_o=0, count=0, flush_pend=0; ready_o=1 after reset.
//  Reset asserted mid-operation discards accumulator and output register contents immediately.
//  State: acc (RATIO lanes), count in 0..RATIO-1, flush_pend, output register (data/keep/valid).
//  - out_free = !valid_o || ready_i. ready_i->ready_o combinational path is intentional.
//  - ready_o = !flush_pend && (count != RATIO-1 || out_free).
//  - Accepted word goes into lane[count]; count increments.
//  - If count==RATIO-1: the full word (acc + data_i) moves to the output register on the same edge.
//    In that case keep_o is all ones and count wraps to 0. Latency is 1 cycle from the last lane to valid_o.
//  - flush_i sets flush_pend if count>0 or a word is accepted in the same cycle.
//    Any word accepted in the flush cycle is included in the flushed word.
//  - flush_i with count==0 and no word accepted is ignored; empty words are never emitted.
//  - While flush_pend=1: no input is accepted. The partial word moves to the output
//    register on the first out_free cycle. keep_o = (1<<count)-1, then count=0 and flush_pend=0.
//  - Output register is loaded only when out_free. An accepted output (valid_o && ready_i)
//    with a simultaneous new load gives back-to-back words with no bubble.
//  - data_o/keep_o are stable while valid_o && !ready_i.
//  - Width: count is $clog2(RATIO) bits. Lane k occupies data_o[k*DATA_WIDTH +: DATA_WIDTH].
// CONFIGURATION
//  STREAM_PACKER_TIMEOUT_EN defined:
//   - An idle counter counts cycles with count>0, flush_pend=0 and no word accepted.
//   - It clears on any accepted word and saturates.
//   - On reaching TIMEOUT it sets flush_pend exactly as flush_i does.
//  Not defined: no counter, TIMEOUT is unused, partial words leave only via flush_i.
// STRUCTURE
//  stream_packer_pkg holds:
//   - localparam functions COUNT_W = $clog2(RATIO) and OUT_W = RATIO*DATA_WIDTH;
//   - typedef lane_keep_t [RATIO-1:0];
//   - a keep_from_count() function.
//  Sub-module: stream_packer_idle_timer (idle counter + threshold compare).
//   - Instantiated only under STREAM_PACKER_TIMEOUT_EN.
//  Everything else stays flat in stream_packer.
// TESTING (DATA_WIDTH=11, RATIO=4, TIMEOUT=8)
//  1. Input 0x001,0x002,0x003,0x004 back-to-back, ready_i=1
//     -> valid_o 1 cycle after 4th word, data_o=0x004_003_002_001 (11-bit lanes), keep_o=4'b1111.
//  2. Input 3 words 0x7FF,0x100,0x0AA, then flush_i
//     -> data_o lanes {0,0x0AA,0x100,0x7FF}, keep_o=4'b0111; next word starts at lane 0.
//  3. ready_i=0 with 8 words streamed
//     -> first packed word held stable; ready_o=0 after 7 accepted.
//     Raise ready_i -> both words delivered in order, no loss or duplication.
//  4. flush_i with count=0 and valid_i=0 -> no output. Flush together with the 4th word -> one full word, keep_o=4'b1111.
//  5. Assert rst_i asynchronously with 2 words buffered and valid_o=1
//     -> valid_o, keep_o and data_o drop to 0 before the next edge. The next 4 words pack from lane 0.
//  6. TIMEOUT_EN: 1 word, then idle 8 cycles -> keep_o=4'b0001 emitted. Without the macro -> no output.

Source files
------------

// File: rtl/stream_packer_pkg.sv
// Shared widths, lane-mask type and keep-mask helper for stream_packer.
package stream_packer_pkg;

   localparam int unsigned DATA_WIDTH = 11;
   localparam int unsigned RATIO      = 4;
   localparam int unsigned COUNT_W    = $clog2(RATIO);
   localparam int unsigned OUT_W      = RATIO * DATA_WIDTH;

   typedef logic [RATIO-1:0]   lane_keep_t;
   typedef logic [COUNT_W-1:0] count_t;

   // Lanes below count are valid: (1 << count) - 1, contiguous from lane 0.
   function automatic lane_keep_t keep_from_count(input count_t count);
      lane_keep_t keep;
      for (int k = 0; k < RATIO; k++) begin
         keep[k] = (k < int'(count));
      end
      return keep;
   endfunction

endpackage

// File: rtl/stream_packer_if.sv
// Narrow-in / wide-out handshake bundle of stream_packer, with producer/consumer
// side (master) and packer side (slave) modports.
interface stream_packer_if;
   import stream_packer_pkg::*;

   logic [DATA_WIDTH-1:0] data_i;
   logic                  valid_i;
   logic                  ready_o;
   logic                  flush_i;
   logic [OUT_W-1:0]      data_o;
   lane_keep_t            keep_o;
   logic                  valid_o;
   logic                  ready_i;

   modport master (
      output data_i, valid_i, flush_i, ready_i,
      input  ready_o, data_o, keep_o, valid_o
   );

   modport slave (
      input  data_i, valid_i, flush_i, ready_i,
      output ready_o, data_o, keep_o, valid_o
   );

endinterface

// File: rtl/stream_packer_idle_timer.sv
// Saturating idle-cycle counter; hit marks the TIMEOUT-th consecutive idle cycle.
module stream_packer_idle_timer #(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic idle,
   input  logic accept,
   output logic hit
);
   localparam int unsigned W = $clog2(TIMEOUT + 1);
   localparam logic [W-1:0] LIMIT  = W'(TIMEOUT);
   localparam logic [W-1:0] HIT_AT = W'(TIMEOUT - 1);

   logic [W-1:0] cnt;

   assign hit = idle && (cnt == HIT_AT);

   // Idle cycle counter: cleared by traffic, held at LIMIT once reached.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt <= {W{1'b0}};
      end else if (accept) begin
         cnt <= {W{1'b0}};
      end else if (idle && (cnt != LIMIT)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/stream_packer.sv
// Packs RATIO narrow words into one wide word with a lane keep mask.
// Optional idle auto-flush is enabled by defining STREAM_PACKER_TIMEOUT_EN.
module stream_packer
   import stream_packer_pkg::*;
#(
   parameter int unsigned TIMEOUT = 64
) (
   input  logic           clk_i,
   input  logic           rst_i,
   stream_packer_if.slave bus
);
   localparam count_t LAST_LANE = count_t'(RATIO - 1);

   count_t                           count;
   logic                             flush_pend;
   logic [RATIO-1:0][DATA_WIDTH-1:0] acc;
   logic [OUT_W-1:0]                 data_q;
   lane_keep_t                       keep_q;
   logic                             valid_q;

   logic             out_free;
   logic             last_lane;
   logic             accept;
   logic             full_load;
   logic             flush_req;
   logic             timeout_hit;
   lane_keep_t       cur_keep;
   logic [OUT_W-1:0] full_word;
   logic [OUT_W-1:0] partial_word;

   assign out_free    = !valid_q || bus.ready_i;
   assign last_lane   = (count == LAST_LANE);
   assign bus.ready_o = !flush_pend && (!last_lane || out_free);
   assign accept      = bus.valid_i && bus.ready_o;
   assign full_load   = accept && last_lane;
   // A flush that coincides with the completing word has nothing left to emit.
   assign flush_req   = (bus.flush_i || timeout_hit) && !full_load
                        && ((count != {COUNT_W{1'b0}}) || accept);
   assign cur_keep    = keep_from_count(count);
   assign full_word   = {bus.data_i, acc[RATIO-2:0]};

   assign bus.data_o  = data_q;
   assign bus.keep_o  = keep_q;
   assign bus.valid_o = valid_q;

`ifdef STREAM_PACKER_TIMEOUT_EN
   stream_packer_idle_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_idle_timer (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .idle   ((count != {COUNT_W{1'b0}}) && !flush_pend && !accept),
      .accept (accept),
      .hit    (timeout_hit)
   );
`else
   assign timeout_hit = 1'b0;
`endif

   // Partial word with stale lanes above count forced to zero.
   always_comb begin
      partial_word = {OUT_W{1'b0}};
      for (int k = 0; k < RATIO; k++) begin
         if (cur_keep[k]) begin
            partial_word[k*DATA_WIDTH +: DATA_WIDTH] = acc[k];
         end else begin
            partial_word[k*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{1'b0}};
         end
      end
   end

   // Accumulator, lane count, flush request and output register.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count      <= {COUNT_W{1'b0}};
         flush_pend <= 1'b0;
         acc        <= {(RATIO*DATA_WIDTH){1'b0}};
         data_q     <= {OUT_W{1'b0}};
         keep_q     <= {RATIO{1'b0}};
         valid_q    <= 1'b0;
      end else begin
         if (accept) begin
            acc[count] <= bus.data_i;
            count      <= last_lane ? {COUNT_W{1'b0}} : count + 1'b1;
         end
         if (flush_req) begin
            flush_pend <= 1'b1;
         end
         if (out_free) begin
            if (full_load) begin
               data_q  <= full_word;
               keep_q  <= {RATIO{1'b1}};
               valid_q <= 1'b1;
            end else if (flush_pend) begin
               data_q     <= partial_word;
               keep_q     <= cur_keep;
               valid_q    <= 1'b1;
               count      <= {COUNT_W{1'b0}};
               flush_pend <= 1'b0;
            end else begin
               valid_q <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_stream_packer.sv
// Directed scenarios plus random traffic for stream_packer against a
// word-list scoreboard model (TIMEOUT=8).
module tb_stream_packer;
   import stream_packer_pkg::*;

   logic clk;
   logic rst;

   stream_packer_if bus ();

   stream_packer #(
      .TIMEOUT (8)
   ) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int unsigned vectors = 0;
   int unsigned errors  = 0;
   int          n_acc   = 0;
   int          idle_n  = 0;

   logic [DATA_WIDTH-1:0] cur[$];
   logic [OUT_W-1:0]      exp_data[$];
   lane_keep_t            exp_keep[$];

   logic             prev_hold = 1'b0;
   logic [OUT_W-1:0] prev_data;
   lane_keep_t       prev_keep;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time exceeded, required completion");
      $fatal(1);
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Close the current list of accepted words into one expected packed word.
   task automatic close_packet();
      logic [OUT_W-1:0] w;
      logic [OUT_W-1:0] lane;
      w = '0;
      foreach (cur[i]) begin
         lane = '0;
         lane[DATA_WIDTH-1:0] = cur[i];
         w = w | (lane << (i * DATA_WIDTH));
      end
      exp_data.push_back(w);
      exp_keep.push_back(lane_keep_t'((1 << cur.size()) - 1));
      cur.delete();
   endtask

   task automatic sample();
      logic acc_now;
      acc_now = bus.valid_i && bus.ready_o;
      if (prev_hold) begin
         check_eq("hold_data", 64'(bus.data_o), 64'(prev_data));
         check_eq("hold_keep", 64'(bus.keep_o), 64'(prev_keep));
         check_eq("hold_valid", 64'(bus.valid_o), 64'd1);
      end
      prev_hold = bus.valid_o && !bus.ready_i;
      prev_data = bus.data_o;
      prev_keep = bus.keep_o;
      if (bus.valid_o && bus.ready_i) begin
         if (exp_data.size() == 0) begin
            check_eq("spurious_out", 64'(bus.valid_o), 64'd0);
         end else begin
            check_eq("out_data", 64'(bus.data_o), 64'(exp_data.pop_front()));
            check_eq("out_keep", 64'(bus.keep_o), 64'(exp_keep.pop_front()));
         end
      end
      if (acc_now) begin
         cur.push_back(bus.data_i);
         n_acc++;
      end
      if (cur.size() == RATIO) close_packet();
      if (bus.flush_i && (cur.size() > 0)) close_packet();
`ifdef STREAM_PACKER_TIMEOUT_EN
      if (acc_now) begin
         idle_n = 0;
      end else if (cur.size() > 0) begin
         idle_n++;
         if (idle_n == 8) close_packet();
      end
`endif
   endtask

   task automatic step();
      @(negedge clk);
      sample();
      @(posedge clk);
      #1;
   endtask

   task automatic send_words(input int n, input logic [DATA_WIDTH-1:0] first, input logic flush_last);
      int start;
      int guard;
      start = n_acc;
      guard = 0;
      while ((n_acc - start < n) && (guard < 40)) begin
         bus.valid_i = 1'b1;
         bus.data_i  = first + DATA_WIDTH'(n_acc - start);
         bus.flush_i = flush_last && (n_acc - start == n - 1);
         step();
         guard++;
      end
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      check_eq("send_count", 64'(n_acc - start), 64'(n));
   endtask

   initial begin
      rst         = 1'b0;
      bus.data_i  = '0;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b1;
      #2 rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check_eq("rst_valid", 64'(bus.valid_o), 64'd0);
      check_eq("rst_data", 64'(bus.data_o), 64'd0);
      check_eq("rst_keep", 64'(bus.keep_o), 64'd0);
      check_eq("rst_ready", 64'(bus.ready_o), 64'd1);

      // Full word, one cycle latency after the 4th lane.
      send_words(4, 11'h001, 1'b0);
      check_eq("t1_valid", 64'(bus.valid_o), 64'd1);
      check_eq("t1_data", 64'(bus.data_o), 64'({11'h004, 11'h003, 11'h002, 11'h001}));
      check_eq("t1_keep", 64'(bus.keep_o), 64'(4'b1111));
      step();

      // Three words then flush.
      send_words(1, 11'h7FF, 1'b0);
      send_words(1, 11'h100, 1'b0);
      send_words(1, 11'h0AA, 1'b0);
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      step();
      check_eq("t2_valid", 64'(bus.valid_o), 64'd1);
      check_eq("t2_data", 64'(bus.data_o), 64'({11'h000, 11'h0AA, 11'h100, 11'h7FF}));
      check_eq("t2_keep", 64'(bus.keep_o), 64'(4'b0111));
      step();

      // Empty flush ignored; flush with the completing word.
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      step();
      step();
      check_eq("t4_empty_flush", 64'(bus.valid_o), 64'd0);
      send_words(4, 11'h200, 1'b1);
      check_eq("t4_keep", 64'(bus.keep_o), 64'(4'b1111));
      step();
      step();
      check_eq("t4_no_extra", 64'(bus.valid_o), 64'd0);

      // Backpressure: 7 accepted, then stall, then release.
      bus.ready_i = 1'b0;
      send_words(7, 11'h300, 1'b0);
      check_eq("t3_ready_low", 64'(bus.ready_o), 64'd0);
      check_eq("t3_held_valid", 64'(bus.valid_o), 64'd1);
      step();
      bus.ready_i = 1'b1;
      send_words(1, 11'h307, 1'b0);
      repeat (3) step();
      check_eq("t3_drained", 64'(exp_data.size()), 64'd0);

      // Asynchronous reset with buffered data.
      bus.ready_i = 1'b0;
      send_words(6, 11'h400, 1'b0);
      #2 rst = 1'b1;
      #1;
      check_eq("t5_valid", 64'(bus.valid_o), 64'd0);
      check_eq("t5_data", 64'(bus.data_o), 64'd0);
      check_eq("t5_keep", 64'(bus.keep_o), 64'd0);
      cur.delete();
      exp_data.delete();
      exp_keep.delete();
      prev_hold = 1'b0;
      idle_n = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      bus.ready_i = 1'b1;
      send_words(4, 11'h010, 1'b0);
      check_eq("t5_repack", 64'(bus.data_o), 64'({11'h013, 11'h012, 11'h011, 11'h010}));
      step();

      // Idle behaviour with a single buffered word.
      send_words(1, 11'h155, 1'b0);
`ifdef STREAM_PACKER_TIMEOUT_EN
      repeat (9) step();
      check_eq("t6_valid", 64'(bus.valid_o), 64'd1);
      check_eq("t6_keep", 64'(bus.keep_o), 64'(4'b0001));
      check_eq("t6_data", 64'(bus.data_o), 64'h155);
      step();
`else
      repeat (12) step();
      check_eq("t6_no_timeout", 64'(bus.valid_o), 64'd0);
      bus.flush_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      repeat (2) step();
`endif

      // Random traffic.
      for (int c = 0; c < 800; c++) begin
         bus.valid_i = ($urandom_range(0, 3) != 0);
         bus.data_i  = DATA_WIDTH'($urandom);
         bus.flush_i = ($urandom_range(0, 15) == 0);
         bus.ready_i = ($urandom_range(0, 3) != 0);
         if ((c % 100) > 85) bus.valid_i = 1'b0;
         step();
      end
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b1;
      bus.ready_i = 1'b1;
      step();
      bus.flush_i = 1'b0;
      repeat (6) step();
      check_eq("final_drain", 64'(exp_data.size()), 64'd0);
      check_eq("final_valid", 64'(bus.valid_o), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
